// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM read/write path controllers of the
// 4-bank x 4096-row x 512-column x16 device: command encodings, address field
// widths, the packed upstream address layout and the write FSM state enum.
// -----------------------------------------------------------------------------
package sdram_pkg;

   // Field widths
   localparam int unsigned CMD_W     = 4;
   localparam int unsigned BA_W      = 2;
   localparam int unsigned ROW_W     = 12;
   localparam int unsigned COL_W     = 9;
   localparam int unsigned SD_ADDR_W = 12;
   localparam int unsigned ADDR_IN_W = 25;
   localparam int unsigned DATA_W    = 16;
   localparam int unsigned BLEN_W    = 8;
   localparam int unsigned WAIT_W    = 8;

   // SDRAM commands {cs_n, ras_n, cas_n, we_n}
   localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
   localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
   localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
   localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
   localparam logic [CMD_W-1:0] CMD_BSTOP     = 4'b0110;
   localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;

   // Idle bus values and precharge-all address (A10 set)
   localparam logic [BA_W-1:0]      BA_IDLE      = 2'b11;
   localparam logic [SD_ADDR_W-1:0] SD_ADDR_IDLE = 12'hFFF;
   localparam logic [SD_ADDR_W-1:0] SD_ADDR_A10  = 12'h400;

   // Upstream linear address {bank[24:23], row[22:11], unused[10:9], col[8:0]}
   typedef struct packed {
      logic [BA_W-1:0]  ba;
      logic [ROW_W-1:0] row;
      logic [1:0]       rsvd;
      logic [COL_W-1:0] col;
   } sdram_addr_t;

   // Write-path FSM states
   typedef enum logic [3:0] {
      WR_IDLE,
      WR_ACTIVE,
      WR_TRCD,
      WR_WRITE,
      WR_DATA,
      WR_BSTOP,
      WR_TWR,
      WR_PRE,
      WR_TRP,
      WR_END
   } wr_state_e;

   // Preset for sdram_wait_cnt so that done rises after clk_cnt cycles
   function automatic logic [WAIT_W-1:0] wait_preset(input int unsigned clk_cnt);
      return WAIT_W'(clk_cnt - 32'd1);
   endfunction

endpackage

// File: rtl/sdram_wait_cnt.sv
// -----------------------------------------------------------------------------
// sdram_wait_cnt
// Loadable down-counter used to time the NOP gaps (tRCD, tWR, tRP) of the
// SDRAM controllers. Counts down to zero and holds there.
//
// Ports:
//   sys_clk   in  1  clock, rising edge
//   sys_rst   in  1  asynchronous active-high reset
//   load      in  1  load load_val this cycle
//   load_val  in  W  preset value (N-1 for an N-cycle wait)
//   done_c    out 1  combinational: counter is at zero
// -----------------------------------------------------------------------------
module sdram_wait_cnt
   import sdram_pkg::*;
#(
   parameter int unsigned W = WAIT_W
)(
   input  logic         sys_clk,
   input  logic         sys_rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done_c
);

   logic [W-1:0] cnt_q;

   // Down-counter, saturating at zero
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign done_c = (cnt_q == '0);

endmodule

// File: rtl/sdram_write.sv
// -----------------------------------------------------------------------------
// sdram_write
// Write-path controller: ACTIVE -> WRITE (full-page burst) -> BURST STOP ->
// PRECHARGE (all banks), pulling words from an upstream show-ahead FIFO.
// Starts only once init_end is high; cmd/ba/addr are muxed onto the pins by
// the top-level arbiter.
//
// Optional build macro: SDRAM_WR_STATS_EN adds wr_word_cnt.
//
// Ports:
//   sys_clk      in  1   100 MHz system clock
//   sys_rst      in  1   asynchronous active-high reset
//   init_end     in  1   SDRAM initialisation complete
//   wr_en        in  1   write request, sampled in IDLE
//   wr_addri     in  25  {bank, row, unused, col}
//   wr_data      in  16  FIFO head word
//   wr_blength   in  8   burst length in words (0 is ignored)
//   wr_ack       out 1   combinational FIFO pop strobe
//   wr_end       out 1   one-cycle completion pulse
//   wr_sdram_en  out 1   combinational Dq output enable
//   wr_cmdo      out 4   {cs_n, ras_n, cas_n, we_n}
//   wr_bao       out 2   bank address
//   wr_addro     out 12  SDRAM address
//   wr_datao     out 16  data to Dq (zero when not driving)
//   wr_word_cnt  out 32  words written since reset (SDRAM_WR_STATS_EN only)
// -----------------------------------------------------------------------------
module sdram_write
   import sdram_pkg::*;
#(
   parameter int unsigned TRCD_CLK = 2,
   parameter int unsigned TWR_CLK  = 2,
   parameter int unsigned TRP_CLK  = 2
)(
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 init_end,
   input  logic                 wr_en,
   input  logic [ADDR_IN_W-1:0] wr_addri,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [BLEN_W-1:0]    wr_blength,
   output logic                 wr_ack,
   output logic                 wr_end,
   output logic                 wr_sdram_en,
   output logic [CMD_W-1:0]     wr_cmdo,
   output logic [BA_W-1:0]      wr_bao,
   output logic [SD_ADDR_W-1:0] wr_addro,
   output logic [DATA_W-1:0]    wr_datao
`ifdef SDRAM_WR_STATS_EN
   ,
   output logic [31:0]          wr_word_cnt
`endif
);

   wr_state_e state_q, state_d;

   sdram_addr_t        addr_in_c;
   logic               rsvd_unused;
   logic [BA_W-1:0]    bank_q;
   logic [ROW_W-1:0]   row_q;
   logic [COL_W-1:0]   col_q;
   logic [BLEN_W-1:0]  blength_q;
   logic [BLEN_W-1:0]  burst_cnt_q;

   logic               start_c;
   logic               burst_last_c;
   logic               wait_load_c;
   logic [WAIT_W-1:0]  wait_val_c;
   logic               wait_done_c;

   logic [CMD_W-1:0]     cmd_d;
   logic [BA_W-1:0]      ba_d;
   logic [SD_ADDR_W-1:0] addr_d;

   assign addr_in_c   = sdram_addr_t'(wr_addri);
   assign rsvd_unused = ^addr_in_c.rsvd;

   assign start_c      = init_end & wr_en & (wr_blength != '0);
   // burst_cnt_q counts acked words; the cycle where it reaches blength-1 is the last word
   assign burst_last_c = (burst_cnt_q == blength_q - BLEN_W'(1));

   // Next-state logic and wait-counter presets
   always_comb begin
      state_d     = state_q;
      wait_load_c = 1'b0;
      wait_val_c  = '0;
      unique case (state_q)
         WR_IDLE:   if (start_c) state_d = WR_ACTIVE;
         WR_ACTIVE: begin
            state_d     = WR_TRCD;
            wait_load_c = 1'b1;
            wait_val_c  = wait_preset(TRCD_CLK);
         end
         WR_TRCD:   if (wait_done_c) state_d = WR_WRITE;
         WR_WRITE,
         WR_DATA:   state_d = burst_last_c ? WR_BSTOP : WR_DATA;
         WR_BSTOP:  begin
            state_d     = WR_TWR;
            wait_load_c = 1'b1;
            wait_val_c  = wait_preset(TWR_CLK);
         end
         WR_TWR:    if (wait_done_c) state_d = WR_PRE;
         WR_PRE:    begin
            state_d     = WR_TRP;
            wait_load_c = 1'b1;
            wait_val_c  = wait_preset(TRP_CLK);
         end
         WR_TRP:    if (wait_done_c) state_d = WR_END;
         WR_END:    state_d = WR_IDLE;
         default:   state_d = WR_IDLE;
      endcase
   end

   // Bus decode of the upcoming state so cmd/ba/addr come straight from flops.
   // ACTIVE is only entered from IDLE, where the live input address is the one being latched.
   always_comb begin
      cmd_d  = CMD_NOP;
      ba_d   = BA_IDLE;
      addr_d = SD_ADDR_IDLE;
      unique case (state_d)
         WR_ACTIVE: begin
            cmd_d  = CMD_ACTIVE;
            ba_d   = addr_in_c.ba;
            addr_d = addr_in_c.row;
         end
         WR_WRITE: begin
            cmd_d  = CMD_WRITE;
            ba_d   = bank_q;
            addr_d = {3'b000, col_q};
         end
         WR_BSTOP: begin
            cmd_d  = CMD_BSTOP;
         end
         WR_PRE: begin
            cmd_d  = CMD_PRECHARGE;
            ba_d   = bank_q;
            addr_d = SD_ADDR_A10;
         end
         default: ;
      endcase
   end

   // State and registered bus outputs
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q  <= WR_IDLE;
         wr_cmdo  <= CMD_NOP;
         wr_bao   <= BA_IDLE;
         wr_addro <= SD_ADDR_IDLE;
         wr_end   <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cmdo  <= cmd_d;
         wr_bao   <= ba_d;
         wr_addro <= addr_d;
         wr_end   <= (state_d == WR_END);
      end
   end

   // Request capture on IDLE -> ACTIVE; held for the whole transaction
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bank_q    <= '0;
         row_q     <= '0;
         col_q     <= '0;
         blength_q <= '0;
      end else if ((state_q == WR_IDLE) && (state_d == WR_ACTIVE)) begin
         bank_q    <= addr_in_c.ba;
         row_q     <= addr_in_c.row;
         col_q     <= addr_in_c.col;
         blength_q <= wr_blength;
      end
   end

   // Acked-word counter for the current burst
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         burst_cnt_q <= '0;
      end else if (state_q == WR_IDLE) begin
         burst_cnt_q <= '0;
      end else if (wr_ack) begin
         burst_cnt_q <= burst_cnt_q + BLEN_W'(1);
      end
   end

   sdram_wait_cnt #(
      .W        (WAIT_W)
   ) u_wait_cnt (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .load     (wait_load_c),
      .load_val (wait_val_c),
      .done_c   (wait_done_c)
   );

   // Data phase: WRITE cycle plus every WR_DATA cycle
   assign wr_ack      = (state_q == WR_WRITE) || (state_q == WR_DATA);
   assign wr_sdram_en = wr_ack;
   assign wr_datao    = wr_sdram_en ? wr_data : '0;

`ifdef SDRAM_WR_STATS_EN
   // Running count of words handed to the SDRAM
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_word_cnt <= '0;
      end else if (wr_ack) begin
         wr_word_cnt <= wr_word_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_write.sv
// -----------------------------------------------------------------------------
// tb_sdram_write
// Directed bench for sdram_write: FIFO model feeding wr_data, a monitor that
// timestamps commands and writes Dq words into a one-row column model, and a
// linear sequence of directed steps with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_sdram_write;

   localparam int unsigned TRCD = 2;
   localparam int unsigned TWR  = 2;
   localparam int unsigned TRP  = 2;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_BST = 4'b0110;
   localparam logic [3:0] C_PRE = 4'b0010;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        init_end;
   logic        wr_en;
   logic [24:0] wr_addri;
   logic [15:0] wr_data;
   logic [7:0]  wr_blength;
   logic        wr_ack;
   logic        wr_end;
   logic        wr_sdram_en;
   logic [3:0]  wr_cmdo;
   logic [1:0]  wr_bao;
   logic [11:0] wr_addro;
   logic [15:0] wr_datao;
`ifdef SDRAM_WR_STATS_EN
   logic [31:0] wr_word_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 sys_clk = ~sys_clk;

   sdram_write #(
      .TRCD_CLK    (TRCD),
      .TWR_CLK     (TWR),
      .TRP_CLK     (TRP)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .init_end    (init_end),
      .wr_en       (wr_en),
      .wr_addri    (wr_addri),
      .wr_data     (wr_data),
      .wr_blength  (wr_blength),
      .wr_ack      (wr_ack),
      .wr_end      (wr_end),
      .wr_sdram_en (wr_sdram_en),
      .wr_cmdo     (wr_cmdo),
      .wr_bao      (wr_bao),
      .wr_addro    (wr_addro),
      .wr_datao    (wr_datao)
`ifdef SDRAM_WR_STATS_EN
      ,
      .wr_word_cnt (wr_word_cnt)
`endif
   );

   // Show-ahead FIFO model: head = data_base + number of pops
   logic [15:0] data_base = 16'h0;
   logic        fifo_clr  = 1'b1;
   int unsigned pop_cnt   = 0;
   always @(posedge sys_clk) begin
      if (fifo_clr)    pop_cnt <= 0;
      else if (wr_ack) pop_cnt <= pop_cnt + 1;
   end
   assign wr_data = data_base + 16'(pop_cnt);

   // Monitor: command timestamps and one-row column model of the SDRAM
   int          cyc = 0;
   int          act_cyc = 0, wr_cyc = 0, bstop_cyc = 0, pre_cyc = 0;
   int          end_cyc = -1000, act_gap = 0, ack_cnt = 0;
   logic [1:0]  act_ba;
   logic [11:0] act_addr, wr_col;
   logic        pre_a10;
   logic [8:0]  ptr;
   logic [15:0] mem [0:511];

   always @(posedge sys_clk) cyc <= cyc + 1;

   always @(negedge sys_clk) begin
      if (sys_rst === 1'b0) begin
         if (wr_cmdo == C_ACT) begin
            act_cyc  = cyc;
            act_gap  = cyc - end_cyc;
            act_ba   = wr_bao;
            act_addr = wr_addro;
            ack_cnt  = 0;
         end
         if (wr_cmdo == C_WR) begin
            wr_cyc = cyc;
            wr_col = wr_addro;
            ptr    = wr_addro[8:0];
         end
         if (wr_sdram_en) begin
            mem[ptr] = wr_datao;
            ptr      = ptr + 9'd1;
         end
         if (wr_ack) ack_cnt++;
         if (wr_cmdo == C_BST) bstop_cyc = cyc;
         if (wr_cmdo == C_PRE) begin
            pre_cyc = cyc;
            pre_a10 = wr_addro[10];
         end
         if (wr_end) end_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the middle of the next low phase (after the monitor has run)
   task automatic step();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic fifo_load(input logic [15:0] base);
      data_base = base;
      fifo_clr  = 1'b1;
      step();
      fifo_clr  = 1'b0;
   endtask

   task automatic wait_act(input string tag);
      int n = 0;
      while (wr_cmdo !== C_ACT && n < 50) begin
         step();
         n++;
      end
      chk(tag, 32'(wr_cmdo), 32'(C_ACT));
   endtask

   task automatic wait_end(input string tag);
      int n = 0;
      while (wr_end !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk(tag, 32'(wr_end), 32'd1);
   endtask

   // Expected offsets from the ACTIVE cycle
   function automatic int e_bst(input int bl);
      return 1 + TRCD + bl;
   endfunction
   function automatic int e_pre(input int bl);
      return e_bst(bl) + 1 + TWR;
   endfunction
   function automatic int e_end(input int bl);
      return e_pre(bl) + 1 + TRP;
   endfunction

   // Timing and data of the transaction that just ended
   task automatic check_txn(input string t, input int bl, input logic [8:0] col,
                            input logic [15:0] base);
      logic [8:0] c;
      chk({t, ".wr_ofs"},  32'(wr_cyc - act_cyc),    32'(1 + TRCD));
      chk({t, ".wr_col"},  32'(wr_col),              32'({3'b000, col}));
      chk({t, ".ack_cnt"}, 32'(ack_cnt),             32'(bl));
      chk({t, ".bst_ofs"}, 32'(bstop_cyc - act_cyc), 32'(e_bst(bl)));
      chk({t, ".pre_ofs"}, 32'(pre_cyc - act_cyc),   32'(e_pre(bl)));
      chk({t, ".pre_a10"}, 32'(pre_a10),             32'd1);
      chk({t, ".end_ofs"}, 32'(end_cyc - act_cyc),   32'(e_end(bl)));
      for (int i = 0; i < bl; i++) begin
         c = col + 9'(i);
         chk($sformatf("%s.mem[%0h]", t, c), 32'(mem[c]), 32'(base + 16'(i)));
      end
   endtask

   initial begin
      sys_rst    = 1'b1;
      init_end   = 1'b0;
      wr_en      = 1'b0;
      wr_addri   = '0;
      wr_blength = '0;
      repeat (3) step();

      // Reset values
      chk("rst.cmd",   32'(wr_cmdo),     32'(C_NOP));
      chk("rst.ba",    32'(wr_bao),      32'h3);
      chk("rst.addr",  32'(wr_addro),    32'hFFF);
      chk("rst.ack",   32'(wr_ack),      32'h0);
      chk("rst.end",   32'(wr_end),      32'h0);
      chk("rst.oe",    32'(wr_sdram_en), 32'h0);
      chk("rst.datao", 32'(wr_datao),    32'h0);
      sys_rst = 1'b0;
      step();

      // wr_en before init_end, then basic 8-word burst at bank 1 row 001 col 004
      fifo_load(16'hA000);
      wr_addri   = {2'b01, 12'h001, 2'b00, 9'h004};
      wr_blength = 8'd8;
      wr_en      = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("gate.nop%0d", i), 32'(wr_cmdo), 32'(C_NOP));
      end
      init_end = 1'b1;
      step();
      chk("basic.act_cmd",  32'(wr_cmdo),  32'(C_ACT));
      chk("basic.act_ba",   32'(wr_bao),   32'h1);
      chk("basic.act_addr", 32'(wr_addro), 32'h001);
      wr_en      = 1'b0;
      wr_addri   = {2'b10, 12'h555, 2'b00, 9'h0AA};
      wr_blength = 8'd3;
      wait_end("basic.end");
      check_txn("basic", 8, 9'h004, 16'hA000);
      step();
      chk("basic.end_pulse", 32'(wr_end),  32'h0);
      chk("basic.idle_cmd",  32'(wr_cmdo), 32'(C_NOP));

      // Single-word burst: BSTOP directly after WRITE
      fifo_load(16'hB000);
      wr_addri   = {2'b00, 12'h020, 2'b00, 9'h020};
      wr_blength = 8'd1;
      wr_en      = 1'b1;
      wait_act("bl1.act");
      wr_en = 1'b0;
      wait_end("bl1.end");
      check_txn("bl1", 1, 9'h020, 16'hB000);
      chk("bl1.bst_after_wr", 32'(bstop_cyc - wr_cyc), 32'd1);
      step();

      // Zero length request is ignored
      wr_blength = 8'd0;
      wr_en      = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         chk($sformatf("bl0.nop%0d", i), 32'(wr_cmdo), 32'(C_NOP));
      end
      wr_en = 1'b0;
      step();

      // Column wrap inside the row
      fifo_load(16'hC000);
      wr_addri   = {2'b11, 12'h3C3, 2'b00, 9'h1FE};
      wr_blength = 8'd4;
      wr_en      = 1'b1;
      wait_act("wrap.act");
      chk("wrap.act_addr", 32'(act_addr), 32'h3C3);
      wr_en = 1'b0;
      wait_end("wrap.end");
      check_txn("wrap", 4, 9'h1FE, 16'hC000);
      step();

      // Back-to-back with a mid-burst request change
      fifo_load(16'h1000);
      wr_addri   = {2'b10, 12'h0AB, 2'b00, 9'h100};
      wr_blength = 8'd4;
      wr_en      = 1'b1;
      wait_act("b2b1.act");
      chk("b2b1.act_ba", 32'(act_ba), 32'h2);
      wr_addri   = {2'b11, 12'h0CD, 2'b00, 9'h140};
      wr_blength = 8'd6;
      wait_end("b2b1.end");
      check_txn("b2b1", 4, 9'h100, 16'h1000);
      step();
      chk("b2b.idle_cmd", 32'(wr_cmdo), 32'(C_NOP));
      step();
      chk("b2b2.act_cmd",  32'(wr_cmdo),  32'(C_ACT));
      chk("b2b2.act_gap",  32'(act_gap),  32'd2);
      chk("b2b2.act_ba",   32'(wr_bao),   32'h3);
      chk("b2b2.act_addr", 32'(wr_addro), 32'h0CD);
      wr_en = 1'b0;
      wait_end("b2b2.end");
      check_txn("b2b2", 6, 9'h140, 16'h1004);
      step();

      // Asynchronous reset during the third data word
      fifo_load(16'hD000);
      wr_addri   = {2'b00, 12'h010, 2'b00, 9'h040};
      wr_blength = 8'd8;
      wr_en      = 1'b1;
      wait_act("rstb.act");
      wr_en = 1'b0;
      for (int n = 0; n < 30 && ack_cnt < 3; n++) step();
      chk("rstb.in_burst", 32'(wr_ack), 32'h1);
      chk("rstb.cmd_mid",  32'(wr_cmdo), 32'(C_NOP));
      #1 sys_rst = 1'b1;
      #1;
      chk("rstb.cmd",   32'(wr_cmdo),     32'(C_NOP));
      chk("rstb.ba",    32'(wr_bao),      32'h3);
      chk("rstb.addr",  32'(wr_addro),    32'hFFF);
      chk("rstb.ack",   32'(wr_ack),      32'h0);
      chk("rstb.end",   32'(wr_end),      32'h0);
      chk("rstb.oe",    32'(wr_sdram_en), 32'h0);
      chk("rstb.datao", 32'(wr_datao),    32'h0);
      step();
      sys_rst = 1'b0;
      step();
      chk("rstb.idle_cmd", 32'(wr_cmdo), 32'(C_NOP));

      // Recovery transaction after reset
      fifo_load(16'hE000);
      wr_addri   = {2'b01, 12'h0EE, 2'b00, 9'h080};
      wr_blength = 8'd2;
      wr_en      = 1'b1;
      wait_act("rec.act");
      chk("rec.act_ba",   32'(act_ba),   32'h1);
      chk("rec.act_addr", 32'(act_addr), 32'h0EE);
      wr_en = 1'b0;
      wait_end("rec.end");
      check_txn("rec", 2, 9'h080, 16'hE000);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
